// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary pointer helpers.
// The helpers work on zero-extended values up to GRAY_MAX_W bits, so one pair of
// functions serves every pointer width. Callers cast the argument and result to
// their own pointer width.
package fifo_pkg;

  localparam int unsigned DEF_ADDR_SIZE = 8;
  localparam int unsigned DEF_DSIZE     = 8;
  localparam int unsigned GRAY_MAX_W    = 32;

  // Binary to reflected Gray code.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  // Upper zero bits leave the result unchanged, so any width up to GRAY_MAX_W works.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    for (int i = 0; i < int'(GRAY_MAX_W); i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry first-word-fall-through output buffer for the FIFO read side.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write push_data this cycle
//   push_data   word returned by the RAM
//   pop         consumer takes the head word (ignored when empty)
//   buf_cnt     registered number of buffered words (0..2)
//   rd_valid    head word is valid (buf_cnt != 0)
//   rd_data     registered head word
module fifo_out_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = DEF_DSIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DSIZE-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       buf_cnt,
  output logic             rd_valid,
  output logic [DSIZE-1:0] rd_data
);

  logic [DSIZE-1:0] tail;
  logic             pop_eff;

  assign pop_eff  = pop & (buf_cnt != 2'd0);
  assign rd_valid = (buf_cnt != 2'd0);

  // The head register is rd_data itself; the head only moves on a pop, so it
  // stays stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_cnt <= 2'd0;
      rd_data <= '0;
      tail    <= '0;
    end else begin
      case ({push, pop_eff})
        2'b10: begin
          if (buf_cnt == 2'd0) rd_data <= push_data;
          else                 tail    <= push_data;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          rd_data <= tail;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            rd_data <= push_data;
          end else begin
            rd_data <= tail;
            tail    <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller (read clock domain only).
// Tracks the binary/Gray read pointer against the synchronized write pointer,
// issues RAM reads and feeds a 2-entry FWFT output buffer.
// Ports:
//   rclk, rrst_n   read clock, asynchronous active-low reset
//   rq2_wptr       synchronized Gray write pointer
//   raddr, ren     RAM read address / enable (data returns next cycle)
//   rdata_mem      RAM read data
//   rptr           registered Gray read pointer to the write domain
//   rempty, raempty, rlevel  registered RAM-side status
//   rd_valid, rd_ready, rd_data  consumer stream
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int unsigned DSIZE      = DEF_DSIZE,
  parameter int unsigned AEMPTY_LVL = 4
) (
  input  logic               rclk,
  input  logic               rrst_n,
  input  logic [ADDR_SIZE:0] rq2_wptr,
  output logic [ADDR_SIZE-1:0] raddr,
  output logic               ren,
  input  logic [DSIZE-1:0]   rdata_mem,
  output logic [ADDR_SIZE:0] rptr,
  output logic               rempty,
  output logic               raempty,
  output logic [ADDR_SIZE:0] rlevel,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [DSIZE-1:0]   rd_data
);

  localparam int unsigned PTR_W = ADDR_SIZE + 1;

  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] rbinnext;
  logic [PTR_W-1:0] rgraynext;
  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] level_next;
  logic             inflight;
  logic [1:0]       buf_cnt;
  logic             pop;
  logic [2:0]       occ_after_pop;

  // Read issue: keep buffered + in-flight words at most 2 after this cycle's pop.
  assign pop           = rd_valid & rd_ready;
  assign occ_after_pop = 3'(buf_cnt) + 3'(inflight) - 3'(pop);
  assign ren           = !rempty && (occ_after_pop < 3'd2);

  // Next pointer and level, computed from the pointer after this cycle's read.
  assign raddr      = rbin[ADDR_SIZE-1:0];
  assign rbinnext   = rbin + PTR_W'(ren);
  assign rgraynext  = PTR_W'(bin2gray(GRAY_MAX_W'(rbinnext)));
  assign wbin       = PTR_W'(gray2bin(GRAY_MAX_W'(rq2_wptr)));
  assign level_next = wbin - rbinnext;

  // Pointer and status registers.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin     <= '0;
      rptr     <= '0;
      rempty   <= 1'b1;
      raempty  <= 1'b1;
      rlevel   <= '0;
      inflight <= 1'b0;
    end else begin
      rbin     <= rbinnext;
      rptr     <= rgraynext;
      rempty   <= (rgraynext == rq2_wptr);
      raempty  <= (level_next <= PTR_W'(AEMPTY_LVL));
      rlevel   <= level_next;
      inflight <= ren;
    end
  end

  // RAM data lands in the buffer the cycle after its read; reset drops it.
  fifo_out_buf #(
    .DSIZE (DSIZE)
  ) u_out_buf (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .push      (inflight),
    .push_data (rdata_mem),
    .pop       (pop),
    .buf_cnt   (buf_cnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
  );

endmodule
